// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//
// Decoupling instruction queue between fetch and decode. Each valid {inst, pc}
// pair from fetch is written into a small circular FIFO; the oldest entry is
// presented to decode. ready_o is derived only from registered occupancy, so
// it never forms a combinational path back into fetch.
//
// Optional build macro:
//   INST_QUEUE_BYPASS_EN - when the queue is empty and decode is not stalled,
//                          a valid input pair is passed straight through to
//                          the outputs and consumed without being stored.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   flush_i       discard all queued instructions this cycle
//   stall_i       pipeline stall vector, only bit STALL_IDX is used
//   inst_i        instruction from fetch
//   pc_i          pc of inst_i
//   inst_valid_i  inst_i/pc_i valid this cycle
//   ready_o       queue can accept one instruction this cycle
//   inst_o        head instruction, `INST_NOP when not valid
//   pc_o          head pc, 0 when not valid
//   inst_valid_o  head entry valid and presented to decode
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_ID
`define STALL_ID 2
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module inst_queue #(
    parameter int DEPTH     = 2,
    parameter int STALL_IDX = `STALL_ID
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [`STALL_WIDTH-1:0] stall_i,
    input  logic [31:0]             inst_i,
    input  logic [31:0]             pc_i,
    input  logic                    inst_valid_i,
    output logic                    ready_o,
    output logic [31:0]             inst_o,
    output logic [31:0]             pc_o,
    output logic                    inst_valid_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic stall;
    logic not_empty;
    logic bypass;
    logic push;
    logic pop;
    logic unused_stall;

    assign stall        = stall_i[STALL_IDX];
    assign unused_stall = ^stall_i;
    assign not_empty    = (count != '0);

    // Occupancy only: a pop in the same cycle does not open a slot for fetch.
    assign ready_o = (count != FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = ~not_empty & inst_valid_i & ~stall & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed pair is consumed by decode directly and must not be stored.
    assign push = inst_valid_i & ready_o & ~flush_i & ~bypass;
    // Based on stored occupancy so a bypass never decrements count.
    assign pop  = not_empty & ~stall & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pc_i, inst_i};
        end
    end

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = `INST_NOP;
        pc_o         = 32'h0;
        if (not_empty) begin
            inst_valid_o = 1'b1;
            inst_o       = mem[rd_ptr][31:0];
            pc_o         = mem[rd_ptr][63:32];
        end else if (bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = inst_i;
            pc_o         = pc_i;
        end
    end

endmodule
